arith_core_mod: RTL and testbench
=================================

Name: arith_core_mod

Overview:
- One compute lane of the NPU convolution engine.
- Each valid cycle it takes a 3x3 window (9 activations) and 9 weights, forms the dot product, and accumulates it over (step+1) consecutive valid windows (channel accumulation).
- Adds bias, requantizes to signed 8 bits, optionally applies ReLU, and optionally applies 4-to-1 max pooling over consecutive results.
- Sits between the input/weight buffers and the output feature-map writer.

Parameters:
- None. All widths are fixed: 8-bit data, 16-bit bias, 24-bit internal accumulator.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in  input  72  nine signed 8-bit activations; element k = in[71-8k -: 8], k=0..8
- weight  input  72  nine signed 8-bit weights, same packing; element k pairs with in element k
- bias  input  16  signed bias, LSB-aligned with the product sum; sampled with the last window of a group
- bound_level  input  2  requantization shift select
- step  input  3  number of windows accumulated per result, minus 1 (0..7)
- en  input  1  window valid; in/weight sampled on a rising clk edge when en=1
- en_relu  input  1  1 = clamp negative results to 0
- en_mp  input  1  1 = output the max of every 4 consecutive results
- out  output  8  signed result
- out_en  output  1  out holds a valid result

Behaviour:
- Reset (asynchronous, active-high): clears out=0, out_en=0, the accumulator, the window counter, the pool counter, the pool max register and all pipeline valids.
- Control inputs (bound_level, step, en_relu, en_mp) are static between resets. Changing them without a reset is undefined.
- Stage 1 (edge N, en=1):
  - p = sum over k of in_k*weight_k, signed, 20-bit.
  - Window counter increments.
  - acc = (counter==0 ? p : acc+p).
- Group end:
  - When counter reaches step, the group is complete.
  - S = acc_final + sign-extended bias, 24-bit.
  - Counter wraps to 0.
- Requantization:
  - Arithmetic right shift by 7/8/9/10 for bound_level 00/01/10/11 (floor, no rounding).
  - Then saturate to [-128,127].
- ReLU: if en_relu=1, negative values become 0.
- Pooling disabled (en_mp=0):
  - The result is registered to out with out_en=1 at edge N+2, where N is the edge that sampled the group's last window.
  - Latency is 2 cycles. Throughput is one result per group.
- Pooling enabled (en_mp=1):
  - Results feed a 2-bit pool counter and a running max (signed compare).
  - The first result of a quad loads the max.
  - On the 4th result, max(r0..r3) is registered to out at edge N+2 of that 4th result's last window.
  - Pool counter wraps to 0.
- Output hold:
  - out changes only when a new result is produced; otherwise it holds.
  - out_en sets on the first produced result and stays 1 until reset.
- en=0 cycles are bubbles: no counter, accumulator or pool state changes. Partial groups and partial quads persist across bubbles.
- Back-to-back operation: windows are accepted every cycle with no stall. Full pipelining is required.
- Reset mid-group: the partial accumulation and partial quad are discarded.

Test Plan:
- step=0, en_mp=0, en_relu=0, bound_level=00, bias=0; in all bytes 0x10, weight all 0x10 every cycle -> out=0x12 (2304>>7=18), out_en=1 from 2 cycles after the first sample, one result per cycle for 64 windows.
- Same stimulus, weight all 0xF0 -> out=0xEE (-18); with en_relu=1 -> out=0x00.
- in all 0x7F, weight all 0x7F -> out=0x7F (saturated); in 0x80, weight 0x7F -> out=0x80.
- step=3, en_mp=0, inputs as in the first scenario -> out=0x48 (9216>>7=72) every 4 cycles. With en asserted one cycle in three -> one new result every 12 cycles; out and out_en=1 hold between results.
- en_mp=1, step=0, windows producing results 1,5,3,2,-4,0,7,6 -> out=0x05 then 0x07, updating every 4 windows. With step=1 -> one output per 8 windows.
- bound_level=10, first-scenario inputs -> out=0x04. Zero inputs with bias=16'h0080, bound_level=00 -> out=0x01. Assert reset mid-group -> out=0 and out_en=0 immediately; the next group starts fresh.

Source files
------------

// File: rtl/arith_core_mod.sv
// One convolution lane: 3x3 dot product, channel accumulation, bias, requantize,
// optional ReLU and optional 4-to-1 max pooling. Two-cycle latency, one window per cycle.
module arith_core_mod (
  input  logic        clk,
  input  logic        reset,
  input  logic [71:0] in,
  input  logic [71:0] weight,
  input  logic [15:0] bias,
  input  logic [1:0]  bound_level,
  input  logic [2:0]  step,
  input  logic        en,
  input  logic        en_relu,
  input  logic        en_mp,
  output logic [7:0]  out,
  output logic        out_en
);

  localparam logic signed [23:0] SAT_MAX = 24'sd127;
  localparam logic signed [23:0] SAT_MIN = -24'sd128;

  function automatic logic signed [7:0] requant(input logic signed [23:0] s,
                                                input logic [1:0] lvl);
    logic signed [23:0] sh;
    sh = s >>> (5'd7 + {3'b000, lvl});
    if (sh > SAT_MAX)      return 8'sh7F;
    else if (sh < SAT_MIN) return 8'sh80;
    else                   return sh[7:0];
  endfunction

  function automatic logic signed [7:0] relu(input logic signed [7:0] x,
                                             input logic on);
    return (on && x < 0) ? 8'sh00 : x;
  endfunction

  logic signed [19:0] prod_sum;
  logic signed [23:0] acc_q, acc_d, acc_sum;
  logic [2:0]         cnt_q, cnt_d;
  logic               last;
  logic signed [23:0] sum_p1;
  logic               vld_p1;
  logic signed [7:0]  res_p2;
  logic               vld_p2;
  logic [1:0]         pcnt_q, pcnt_d;
  logic signed [7:0]  pmax_q, pmax_d, pool_max;
  logic signed [7:0]  out_q, out_d;
  logic               out_en_q, out_en_d;

  always_comb begin
    logic signed [15:0] ak, wk, pk;
    prod_sum = '0;
    for (int k = 0; k < 9; k++) begin
      ak = {{8{in[71-8*k]}}, in[71-8*k -: 8]};
      wk = {{8{weight[71-8*k]}}, weight[71-8*k -: 8]};
      pk = ak * wk;
      prod_sum = prod_sum + {{4{pk[15]}}, pk};
    end
  end

  // Stage 0: accumulate windows of the current group
  assign last    = (cnt_q == step);
  assign acc_sum = (cnt_q == 3'd0) ? {{4{prod_sum[19]}}, prod_sum}
                                   : acc_q + {{4{prod_sum[19]}}, prod_sum};

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (en) begin
      acc_d = acc_sum;
      cnt_d = last ? 3'd0 : cnt_q + 3'd1;
    end
  end

  // Stage 1: group total plus bias, then requantize/ReLU into stage 2
  always_ff @(posedge clk) begin
    if (en && last) sum_p1 <= acc_sum + {{8{bias[15]}}, bias};
    if (vld_p1)     res_p2 <= relu(requant(sum_p1, bound_level), en_relu);
  end

  // Stage 2: pooling and output register
  assign pool_max = (pcnt_q == 2'd0 || res_p2 > pmax_q) ? res_p2 : pmax_q;

  always_comb begin
    pcnt_d   = pcnt_q;
    pmax_d   = pmax_q;
    out_d    = out_q;
    out_en_d = out_en_q;
    if (vld_p2) begin
      if (en_mp) begin
        pmax_d = pool_max;
        pcnt_d = pcnt_q + 2'd1;
        if (pcnt_q == 2'd3) begin
          out_d    = pool_max;
          out_en_d = 1'b1;
        end
      end else begin
        out_d    = res_p2;
        out_en_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      pcnt_q   <= '0;
      pmax_q   <= '0;
      out_q    <= '0;
      out_en_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      vld_p1   <= en && last;
      vld_p2   <= vld_p1;
      pcnt_q   <= pcnt_d;
      pmax_q   <= pmax_d;
      out_q    <= out_d;
      out_en_q <= out_en_d;
    end
  end

  assign out    = out_q;
  assign out_en = out_en_q;

endmodule

// File: tb/tb_arith_core_mod.sv
// Scoreboard bench for arith_core_mod: a behavioural model queues each expected
// result with its due cycle; a negedge monitor checks out/out_en every cycle.
module tb_arith_core_mod;

  logic        clk = 1'b0;
  logic        reset;
  logic [71:0] in_s, weight_s;
  logic [15:0] bias_s;
  logic [1:0]  bl_s;
  logic [2:0]  step_s;
  logic        en_s, relu_s, mp_s;
  logic [7:0]  out_s;
  logic        out_en_s;

  arith_core_mod dut (
    .clk(clk), .reset(reset), .in(in_s), .weight(weight_s), .bias(bias_s),
    .bound_level(bl_s), .step(step_s), .en(en_s), .en_relu(relu_s), .en_mp(mp_s),
    .out(out_s), .out_en(out_en_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] val; int due; } exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;
  logic [7:0] cur_out = 8'h00;
  logic       cur_en  = 1'b0;
  bit         mon_on  = 1'b0;

  int m_acc, m_cnt, m_pcnt, m_max;

  function automatic int dot(input logic [71:0] a, input logic [71:0] w);
    int s = 0;
    for (int k = 0; k < 9; k++) begin
      logic signed [7:0] x, y;
      x = a[71-8*k -: 8];
      y = w[71-8*k -: 8];
      s += int'(x) * int'(y);
    end
    return s;
  endfunction

  function automatic int quant(input int s);
    int v;
    v = s >>> (7 + int'(bl_s));
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    if (relu_s && v < 0) v = 0;
    return v;
  endfunction

  function automatic logic [71:0] rep(input logic [7:0] b);
    return {9{b}};
  endfunction

  // Scoreboard monitor: pops a result on its due cycle, checks hold otherwise
  always @(negedge clk) begin
    if (mon_on && !reset) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        cur_out = q[0].val;
        cur_en  = 1'b1;
        void'(q.pop_front());
      end
      n_chk++;
      if (out_s !== cur_out || out_en_s !== cur_en) begin
        n_fail++;
        $display("FAIL scoreboard cyc=%0d out=%h out_en=%b required out=%h out_en=%b",
                 cyc, out_s, out_en_s, cur_out, cur_en);
      end
    end
  end

  task automatic win(input logic [71:0] a, input logic [71:0] w,
                     input logic [15:0] b, input logic e);
    int r;
    exp_t ex;
    @(posedge clk); #1;
    in_s = a; weight_s = w; bias_s = b; en_s = e;
    if (e) begin
      m_acc = (m_cnt == 0) ? dot(a, w) : m_acc + dot(a, w);
      if (m_cnt == int'(step_s)) begin
        m_cnt = 0;
        r = quant(m_acc + int'($signed(b)));
        if (!mp_s) begin
          ex.val = 8'(r); ex.due = cyc + 3; q.push_back(ex);
        end else begin
          if (m_pcnt == 0 || r > m_max) m_max = r;
          if (m_pcnt == 3) begin
            ex.val = 8'(m_max); ex.due = cyc + 3; q.push_back(ex);
          end
          m_pcnt = (m_pcnt + 1) % 4;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic do_reset(input logic [2:0] st, input logic [1:0] bl,
                          input logic relu, input logic mp);
    @(posedge clk); #1;
    reset = 1'b1; en_s = 1'b0;
    q.delete();
    cur_out = 8'h00; cur_en = 1'b0;
    m_acc = 0; m_cnt = 0; m_pcnt = 0; m_max = 0;
    #1;
    n_chk++;
    if (out_s !== 8'h00 || out_en_s !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_immediate out=%h out_en=%b required out=00 out_en=0", out_s, out_en_s);
    end
    step_s = st; bl_s = bl; relu_s = relu; mp_s = mp;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) win('0, '0, '0, 1'b0);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_final(input string name, input logic [7:0] req);
    n_chk++;
    if (out_s !== req || out_en_s !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out=%h out_en=%b required out=%h out_en=1", name, out_s, out_en_s, req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en_s = 1'b0; in_s = '0; weight_s = '0; bias_s = '0;
    step_s = '0; bl_s = '0; relu_s = 1'b0; mp_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (out_s !== 8'h00 || out_en_s !== 1'b0) begin
      n_fail++;
      $display("FAIL power_on_reset out=%h out_en=%b required out=00 out_en=0", out_s, out_en_s);
    end
    reset = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic test_basic();
    do_reset(3'd0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) win(rep(8'h10), rep(8'h10), 16'h0, 1'b1);
    drain();
    check_final("basic_0x12", 8'h12);
  endtask

  task automatic test_negative();
    do_reset(3'd0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) win(rep(8'h10), rep(8'hF0), 16'h0, 1'b1);
    drain();
    check_final("negative_0xEE", 8'hEE);
    do_reset(3'd0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) win(rep(8'h10), rep(8'hF0), 16'h0, 1'b1);
    drain();
    check_final("relu_zero", 8'h00);
  endtask

  task automatic test_saturate();
    do_reset(3'd0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) win(rep(8'h7F), rep(8'h7F), 16'h0, 1'b1);
    drain();
    check_final("sat_pos", 8'h7F);
    for (int i = 0; i < 3; i++) win(rep(8'h80), rep(8'h7F), 16'h0, 1'b1);
    drain();
    check_final("sat_neg", 8'h80);
  endtask

  task automatic test_accum();
    do_reset(3'd3, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) win(rep(8'h10), rep(8'h10), 16'h0, 1'b1);
    drain();
    check_final("accum_0x48", 8'h48);
    for (int i = 0; i < 30; i++) win(rep(8'h08), rep(8'h10), 16'h0, (i % 3) == 0);
    drain();
    check_final("accum_bubbles", 8'h24);
  endtask

  task automatic test_pool();
    int res[8] = '{1, 5, 3, 2, -4, 0, 7, 6};
    logic [7:0] b;
    do_reset(3'd0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      b = 8'(res[i] * 2);
      win({b, 64'h0}, {8'd64, 64'h0}, 16'h0, 1'b1);
    end
    drain();
    check_final("pool_step0", 8'h07);
    do_reset(3'd1, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      b = 8'(res[i/2]);
      win({b, 64'h0}, {8'd64, 64'h0}, 16'h0, 1'b1);
    end
    drain();
    check_final("pool_step1", 8'h07);
  endtask

  task automatic test_bound_bias();
    do_reset(3'd0, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) win(rep(8'h10), rep(8'h10), 16'h0, 1'b1);
    drain();
    check_final("bound_10", 8'h04);
    do_reset(3'd0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) win('0, '0, 16'h0080, 1'b1);
    drain();
    check_final("bias_only", 8'h01);
  endtask

  task automatic test_reset_mid();
    do_reset(3'd3, 2'd0, 1'b0, 1'b0);
    win(rep(8'h7F), rep(8'h7F), 16'h0, 1'b1);
    win(rep(8'h7F), rep(8'h7F), 16'h0, 1'b1);
    do_reset(3'd3, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) win(rep(8'h10), rep(8'h10), 16'h0, 1'b1);
    drain();
    check_final("after_mid_reset", 8'h48);
  endtask

  task automatic test_back_to_back();
    do_reset(3'd2, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < 60; i++)
      win({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
          16'($urandom), ($urandom_range(0, 3) != 0));
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturate();
    test_accum();
    test_pool();
    test_bound_bias();
    test_reset_mid();
    test_back_to_back();
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
